// File: rtl/itch_param_msg_decoder_if.sv
// ----------------------------------------------------------------------------
// itch_param_msg_decoder_if
//   Bundles the raw byte stream, the output holding-register handshake and
//   the status/counter outputs of one itch_param_msg_decoder instance.
//
//   byte_in / valid_in   raw stream byte and its qualifier (source -> decoder)
//   out_ready            downstream accepts out_payload this cycle
//   out_valid            holding register full
//   out_payload          message bytes 1..LEN-1, byte 1 in the MSBs
//   out_parsed_type      decoder's type code while out_valid, else 0
//   packet_invalid       one-cycle error pulse, qualified by err_code
//   err_code             01 SHORT, 10 LONG, 11 OVERFLOW
//   msg_count/drop_count saturating message counters
//
//   master: stream source and payload consumer.  slave: the decoder.
// ----------------------------------------------------------------------------
interface itch_param_msg_decoder_if #(
  parameter int MSG_LENGTH = 27
);
  logic [7:0]                  byte_in;
  logic                        valid_in;
  logic                        out_ready;
  logic                        out_valid;
  logic [8*(MSG_LENGTH-1)-1:0] out_payload;
  logic [3:0]                  out_parsed_type;
  logic                        packet_invalid;
  logic [1:0]                  err_code;
  logic [15:0]                 msg_count;
  logic [15:0]                 drop_count;

  modport master (
    output byte_in, valid_in, out_ready,
    input  out_valid, out_payload, out_parsed_type,
           packet_invalid, err_code, msg_count, drop_count
  );

  modport slave (
    input  byte_in, valid_in, out_ready,
    output out_valid, out_payload, out_parsed_type,
           packet_invalid, err_code, msg_count, drop_count
  );
endinterface

// File: rtl/itch_param_msg_decoder.sv
// ----------------------------------------------------------------------------
// itch_param_msg_decoder
//   Speculative fixed-length ITCH message decoder.  Watches the shared raw
//   byte stream; when a burst starts with MSG_TYPE it captures bytes
//   1..MSG_LENGTH-1 into a shadow register and, once the message is known to
//   be well framed, commits it into an output ready/valid holding register.
//   Bursts of any other type are skipped until valid_in drops.
//
//   Ports
//     clk   clock, all logic on posedge
//     rst   synchronous active-high reset
//     bus   itch_param_msg_decoder_if.slave (stream in, holding reg out,
//           error pulse/code, saturating msg/drop counters)
//
//   Framing
//     BACK_TO_BACK=0: a message must be followed by a valid_in-low cycle;
//       commit happens on that gap cycle.  An extra valid byte with no gap
//       is a LONG error and the message is dropped.
//     BACK_TO_BACK=1: the byte after the last one is a new type byte; commit
//       happens in the cycle after the last byte.
// ----------------------------------------------------------------------------
module itch_param_msg_decoder #(
  parameter logic [7:0] MSG_TYPE     = 8'h55,
  parameter int         MSG_LENGTH   = 27,
  parameter logic [3:0] PARSED_TYPE  = 4'd4,
  parameter bit         BACK_TO_BACK = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  itch_param_msg_decoder_if.slave  bus
);

  localparam int PW = 8 * (MSG_LENGTH - 1);
  localparam int IW = $clog2(MSG_LENGTH + 1);

  // byte_index == LEN_IDX means "all bytes seen, waiting for the burst end".
  localparam logic [IW-1:0] LEN_IDX  = IW'(MSG_LENGTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SHORT    = 2'b01,
    ERR_LONG     = 2'b10,
    ERR_OVERFLOW = 2'b11
  } err_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e          state_q,       state_d;
  logic [IW-1:0]   idx_q,         idx_d;
  logic [PW-1:0]   shadow_q,      shadow_d;
  logic            commit_pend_q, commit_pend_d;
  logic            out_valid_q,   out_valid_d;
  logic [PW-1:0]   payload_q,     payload_d;
  err_e            err_q,         err_d;
  logic [15:0]     msg_cnt_q,     msg_cnt_d;
  logic [15:0]     drop_cnt_q,    drop_cnt_d;

  err_e            fsm_err;
  logic            gap_commit;
  logic            commit;

  // --------------------------------------------------------------------------
  // Framing FSM and shadow capture
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    commit_pend_d = 1'b0;
    gap_commit    = 1'b0;
    fsm_err       = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          if (bus.byte_in == MSG_TYPE) begin
            state_d = CAPTURE;
            idx_d   = IW'(1);
          end else begin
            state_d = SKIP;
          end
        end
      end

      CAPTURE: begin
        if (bus.valid_in) begin
          if (idx_q == LEN_IDX) begin
            // Burst ran past the message with no gap: drop the whole thing.
            fsm_err = ERR_LONG;
            state_d = SKIP;
            idx_d   = '0;
          end else begin
            for (int k = 1; k < MSG_LENGTH; k++) begin
              if (idx_q == IW'(k)) shadow_d[PW-8*k +: 8] = bus.byte_in;
            end
            idx_d = idx_q + IW'(1);
            if (BACK_TO_BACK && idx_q == LAST_IDX) begin
              commit_pend_d = 1'b1;
              state_d       = IDLE;
              idx_d         = '0;
            end
          end
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          if (idx_q == LEN_IDX) gap_commit = 1'b1;
          else                  fsm_err    = ERR_SHORT;
        end
      end

      SKIP: begin
        if (!bus.valid_in) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Both framing modes commit from a complete shadow; the FSM never writes
  // the shadow in the commit cycle, so no bypass is needed.
  assign commit = BACK_TO_BACK ? commit_pend_q : gap_commit;

  // --------------------------------------------------------------------------
  // Holding register, error reporting, counters
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    msg_cnt_d   = msg_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    err_d       = fsm_err;

    if (commit) begin
      if (out_valid_q && !bus.out_ready) begin
        // Old message still unconsumed: the new one is lost, old one kept.
        err_d = ERR_OVERFLOW;
      end else begin
        out_valid_d = 1'b1;
        payload_d   = shadow_q;
        msg_cnt_d   = sat_inc(msg_cnt_q);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // The FSM and the commit path are mutually exclusive in time, so at
    // most one error source is active in any cycle.
    if (err_d != ERR_NONE) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      commit_pend_q <= 1'b0;
      out_valid_q   <= 1'b0;
      payload_q     <= '0;
      err_q         <= ERR_NONE;
      msg_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      commit_pend_q <= commit_pend_d;
      out_valid_q   <= out_valid_d;
      payload_q     <= payload_d;
      err_q         <= err_d;
      msg_cnt_q     <= msg_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // NOTE: the shadow is a data-only register; it is never observable until
  // a full message overwrites every slot, so it carries no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_payload     = payload_q;
  assign bus.out_parsed_type = out_valid_q ? PARSED_TYPE : 4'd0;
  assign bus.packet_invalid  = (err_q != ERR_NONE);
  assign bus.err_code        = err_q;
  assign bus.msg_count       = msg_cnt_q;
  assign bus.drop_count      = drop_cnt_q;

endmodule

// File: tb/tb_itch_param_msg_decoder.sv
// ----------------------------------------------------------------------------
// tb_itch_param_msg_decoder
//   Two decoders (BACK_TO_BACK=0 and =1) share one stimulus stream.  Negedge
//   monitors log every error pulse and every accepted payload per instance;
//   directed vectors and hand sequences compare those logs and the counters
//   against hand-derived expectations.
// ----------------------------------------------------------------------------
module tb_itch_param_msg_decoder;

  localparam int LEN = 27;
  localparam int PW  = 8 * (LEN - 1);

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] byte_d  = 8'h00;
  logic       valid_d = 1'b0;
  logic       ready_d = 1'b0;

  always #5 clk = ~clk;

  itch_param_msg_decoder_if #(.MSG_LENGTH(LEN)) if0 ();
  itch_param_msg_decoder_if #(.MSG_LENGTH(LEN)) if1 ();

  assign if0.byte_in   = byte_d;
  assign if0.valid_in  = valid_d;
  assign if0.out_ready = ready_d;
  assign if1.byte_in   = byte_d;
  assign if1.valid_in  = valid_d;
  assign if1.out_ready = ready_d;

  itch_param_msg_decoder #(
    .MSG_TYPE(8'h55), .MSG_LENGTH(LEN), .PARSED_TYPE(4'd4), .BACK_TO_BACK(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  itch_param_msg_decoder #(
    .MSG_TYPE(8'h55), .MSG_LENGTH(LEN), .PARSED_TYPE(4'd4), .BACK_TO_BACK(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [PW-1:0] acc0 [64];
  logic [3:0]    typ0 [64];
  int            acc0_n = 0;
  int            err0 [4] = '{default: 0};
  logic [PW-1:0] acc1 [64];
  logic [3:0]    typ1 [64];
  int            acc1_n = 0;
  int            err1 [4] = '{default: 0};

  always @(negedge clk) begin
    if (if0.packet_invalid) err0[if0.err_code]++;
    if (if1.packet_invalid) err1[if1.err_code]++;
    if (if0.out_valid && ready_d && acc0_n < 64) begin
      acc0[acc0_n] = if0.out_payload;
      typ0[acc0_n] = if0.out_parsed_type;
      acc0_n++;
    end
    if (if1.out_valid && ready_d && acc1_n < 64) begin
      acc1[acc1_n] = if1.out_payload;
      typ1[acc1_n] = if1.out_parsed_type;
      acc1_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] stim [$];
  int a0, a1;
  int e0 [4];
  int e1 [4];

  task automatic drive(input logic [7:0] b, input logic v);
    @(posedge clk);
    #1;
    byte_d  = b;
    valid_d = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0);
  endtask

  task automatic play();
    foreach (stim[i]) drive(stim[i], 1'b1);
    drive(8'h00, 1'b0);
  endtask

  task automatic add_msg(input logic [7:0] tp, input int n, input logic [7:0] seed);
    stim.push_back(tp);
    for (int k = 1; k < n; k++) stim.push_back(seed + 8'(k));
  endtask

  function automatic logic [PW-1:0] pay_of(input int start);
    logic [PW-1:0] p = '0;
    for (int k = 1; k < LEN; k++) p = {p[PW-9:0], stim[start+k]};
    return p;
  endfunction

  task automatic snap();
    a0 = acc0_n;
    a1 = acc1_n;
    e0 = err0;
    e1 = err1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    valid_d = 1'b0;
    byte_d  = 8'h00;
    idle(2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    snap();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] tp;
    int         n;
    logic       rdy;
    int         exp_acc;
    int         exp_short;
    int         exp_long;
    logic       exp_ov;
    int         exp_msg;
    int         exp_drop;
  } vec_t;

  vec_t          vecs [8];
  logic [PW-1:0] pa, pb;

  initial begin
    vecs[0] = '{8'h55, 27, 1'b1, 1, 0, 0, 1'b0, 1, 0};
    vecs[1] = '{8'h55, 11, 1'b1, 0, 1, 0, 1'b0, 0, 1};
    vecs[2] = '{8'h55, 28, 1'b1, 0, 0, 1, 1'b0, 0, 1};
    vecs[3] = '{8'h41, 36, 1'b1, 0, 0, 0, 1'b0, 0, 0};
    vecs[4] = '{8'h55,  1, 1'b1, 0, 1, 0, 1'b0, 0, 1};
    vecs[5] = '{8'h55,  2, 1'b1, 0, 1, 0, 1'b0, 0, 1};
    vecs[6] = '{8'h55, 27, 1'b0, 0, 0, 0, 1'b1, 1, 0};
    vecs[7] = '{8'h55, 26, 1'b1, 0, 1, 0, 1'b0, 0, 1};

    // Reset state
    do_reset();
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_payload", if0.out_payload, 0);
    check("rst_ptype", if0.out_parsed_type, 0);
    check("rst_invalid", if0.packet_invalid, 0);
    check("rst_err", if0.err_code, 0);
    check("rst_msg", if0.msg_count, 0);
    check("rst_drop", if0.drop_count, 0);
    check("rst_out_valid_b2b", if1.out_valid, 0);

    // Table: one burst + gap on the gap-framed decoder
    foreach (vecs[i]) begin
      do_reset();
      ready_d = vecs[i].rdy;
      stim.delete();
      add_msg(vecs[i].tp, vecs[i].n, 8'h20);
      play();
      idle(3);
      check($sformatf("v%0d_msg", i), if0.msg_count, vecs[i].exp_msg);
      check($sformatf("v%0d_drop", i), if0.drop_count, vecs[i].exp_drop);
      check($sformatf("v%0d_acc", i), acc0_n - a0, vecs[i].exp_acc);
      check($sformatf("v%0d_short", i), err0[1] - e0[1], vecs[i].exp_short);
      check($sformatf("v%0d_long", i), err0[2] - e0[2], vecs[i].exp_long);
      check($sformatf("v%0d_ovf", i), err0[3] - e0[3], 0);
      check($sformatf("v%0d_code0", i), err0[0] - e0[0], 0);
      check($sformatf("v%0d_out_valid", i), if0.out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_acc == 1) begin
        check($sformatf("v%0d_payload", i), acc0[a0], pay_of(0));
        check($sformatf("v%0d_ptype", i), typ0[a0], 4'd4);
      end
      if (vecs[i].exp_ov) check($sformatf("v%0d_held", i), if0.out_payload, pay_of(0));
    end
    ready_d = 1'b0;

    // 1: documented U message
    do_reset();
    ready_d = 1'b1;
    stim = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
             8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h27, 8'h10, 8'h00, 8'h00};
    play();
    idle(3);
    check("t1_acc", acc0_n - a0, 1);
    check("t1_payload", acc0[a0],
          208'h0102030405060708_1112131415161718_00000064_00002710_0000);
    check("t1_ptype", typ0[a0], 4'd4);
    check("t1_msg", if0.msg_count, 1);
    check("t1_out_valid_after", if0.out_valid, 0);
    check("t1_b2b_payload", acc1[a1], 208'h0102030405060708_1112131415161718_00000064_00002710_0000);

    // 3: two U messages with no gap between them
    do_reset();
    ready_d = 1'b1;
    stim.delete();
    add_msg(8'h55, LEN, 8'h30);
    add_msg(8'h55, LEN, 8'h50);
    play();
    idle(3);
    check("t3_long", err0[2] - e0[2], 1);
    check("t3_msg", if0.msg_count, 0);
    check("t3_acc", acc0_n - a0, 0);
    check("t3_b2b_msg", if1.msg_count, 2);
    check("t3_b2b_acc", acc1_n - a1, 2);
    check("t3_b2b_pay0", acc1[a1], pay_of(0));
    check("t3_b2b_pay1", acc1[a1+1], pay_of(LEN));
    check("t3_b2b_drop", if1.drop_count, 0);

    // 4a: overflow while holding register is full
    do_reset();
    ready_d = 1'b0;
    stim.delete();
    add_msg(8'h55, LEN, 8'h60);
    pa = pay_of(0);
    play();
    stim.delete();
    add_msg(8'h55, LEN, 8'h70);
    play();
    idle(2);
    check("t4a_ovf", err0[3] - e0[3], 1);
    check("t4a_drop", if0.drop_count, 1);
    check("t4a_msg", if0.msg_count, 1);
    check("t4a_held", if0.out_payload, pa);
    ready_d = 1'b1;
    idle(2);
    check("t4a_acc", acc0_n - a0, 1);
    check("t4a_acc_pay", acc0[a0], pa);
    check("t4a_out_valid", if0.out_valid, 0);

    // 4b: consume on the second commit cycle -> replacement, no error
    do_reset();
    ready_d = 1'b0;
    stim.delete();
    add_msg(8'h55, LEN, 8'h60);
    pa = pay_of(0);
    play();
    stim.delete();
    add_msg(8'h55, LEN, 8'h70);
    pb = pay_of(0);
    foreach (stim[i]) drive(stim[i], 1'b1);
    @(posedge clk);
    #1;
    byte_d  = 8'h00;
    valid_d = 1'b0;
    ready_d = 1'b1;
    idle(3);
    check("t4b_ovf", err0[3] - e0[3], 0);
    check("t4b_msg", if0.msg_count, 2);
    check("t4b_acc", acc0_n - a0, 2);
    check("t4b_pay_a", acc0[a0], pa);
    check("t4b_pay_b", acc0[a0+1], pb);

    // 5: foreign 36-byte message skipped, then U decoded
    do_reset();
    ready_d = 1'b1;
    stim.delete();
    add_msg(8'h41, 36, 8'h80);
    play();
    stim.delete();
    add_msg(8'h55, LEN, 8'h90);
    play();
    idle(3);
    check("t5_acc", acc0_n - a0, 1);
    check("t5_pay", acc0[a0], pay_of(0));
    check("t5_drop", if0.drop_count, 0);
    check("t5_msg", if0.msg_count, 1);

    // 6: reset in the middle of a message
    do_reset();
    ready_d = 1'b1;
    stim.delete();
    add_msg(8'h55, LEN, 8'hA0);
    for (int i = 0; i < 12; i++) drive(stim[i], 1'b1);
    rst = 1'b1;
    for (int i = 12; i < LEN; i++) drive(stim[i], 1'b1);
    drive(8'h00, 1'b0);
    rst = 1'b0;
    snap();
    idle(2);
    check("t6_msg0", if0.msg_count, 0);
    check("t6_drop0", if0.drop_count, 0);
    check("t6_valid0", if0.out_valid, 0);
    check("t6_err0", err0[1] + err0[2] + err0[3] - e0[1] - e0[2] - e0[3], 0);
    stim.delete();
    add_msg(8'h55, LEN, 8'hB0);
    play();
    idle(3);
    check("t6_msg1", if0.msg_count, 1);
    check("t6_acc", acc0_n - a0, 1);
    check("t6_pay", acc0[a0], pay_of(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
